muldiv_controller: RTL
======================

# muldiv_controller

Iterative multiply/divide sequencer for the EX stage of the five-stage pipeline. It accepts MULT/MULTU/DIV/DIVU requests from EX, runs a 32-iteration shift-add or restoring-divide datapath, and stalls the pipeline while busy. It owns and writes the HI/LO registers. It sits beside the ALU and is driven by the decoded mul/div operation carried from `control_unit` into EX.

## Interface
- `WIDTH`, 32, operand width. HI and LO are each WIDTH bits. The iteration count equals WIDTH.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `startE`  in  1  the EX-stage instruction is a mul/div.
- `opE`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `srcAE`  in  WIDTH  rs value (multiplicand or dividend).
- `srcBE`  in  WIDTH  rt value (multiplier or divisor).
- `flushE`  in  1  EX instruction cancelled.
- `stallE`  out  1  freeze PC, IF/ID and ID/EX.
- `busy`  out  1  state is RUN.
- `done`  out  1  one-cycle pulse when HI/LO are updated.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:**
  - If `startE && !flushE`, latch the operation and the operand magnitudes, and record the result signs. Signs apply only to signed ops; unsigned ops use the raw operands.
  - Clear the 5-bit iteration counter and go to RUN.
  - Otherwise stay in IDLE.
- **RUN:** one iteration per cycle.
  - Multiply: 64-bit accumulator, shift-add on the LSB of the multiplier.
  - Divide: restoring divide with a 33-bit partial remainder and one quotient bit per cycle.
  - When the counter reaches WIDTH-1, apply sign correction and write HI/LO on the same edge, then go to DONE.
  - `startE` is ignored in RUN.
- **DONE:** assert `done`, ignore `startE`, and go to IDLE. The mul/div instruction is still in EX in this cycle, so `startE` must not restart the unit.
- **Flush:** `flushE` in RUN returns the unit to IDLE on the next edge.
  - HI/LO are unchanged and `done` is not pulsed.
  - `flushE` in IDLE suppresses the start.
- **Result mapping:**
  - Multiply: HI = upper 32 bits, LO = lower 32 bits of the product.
  - Signed multiply: the product is negated when the operand signs differ.
  - Divide: LO = quotient, HI = remainder.
  - Signed divide: the quotient is negative when the signs differ. The remainder takes the sign of the dividend. Truncation is toward zero.
- **Divide by zero** (srcB == 0), signed or unsigned:
  - LO = 0xFFFFFFFF, HI = dividend (the original srcA bits).
  - Full latency still applies.
- **Signed overflow** (0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0.
- All arithmetic is done on magnitudes, with the final two's-complement correction applied in the write-back edge only.

## Timing
- **Reset:**
  - State = IDLE, counter = 0, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0.
  - `stallE` is forced to 0 while `rst` is high.
- **Cycle numbering:** cycle 0 is the cycle in which `startE` is sampled in IDLE.
- `stallE = !rst && ((IDLE && startE && !flushE) || RUN)`.
  - This is combinational, so the stall is visible in cycle 0.
- **Schedule:**
  - Cycles 1..32: RUN, `busy` = 1, `stallE` = 1.
  - The edge ending cycle 32 writes HI/LO.
  - Cycle 33: DONE, `done` = 1, `stallE` = 0, new `hi`/`lo` visible. The instruction leaves EX at the end of cycle 33.
  - Cycle 34: IDLE. A new start is accepted from cycle 34 onward.
- **Total:** 33 stall cycles (cycles 0..32) per mul/div.
- **Reset mid-operation:** IDLE on the next edge, HI/LO cleared, no `done`.
- **Same-cycle `flushE` and final iteration:** flush wins. HI/LO are not written.
- **HI/LO readers (MFHI/MFLO)** observe the registers directly. A write in the DONE cycle is visible to an instruction in EX at cycle 34.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF at cycle 0 -> `stallE` high in cycles 0..32; cycle 33 `done` = 1, `hi` = 0xFFFFFFFE, `lo` = 0x00000001; cycle 34 `busy` = 0.
- MULT 0xFFFFFFFD (−3) × 5 -> `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF1. Then DIV 0xFFFFFFF9 (−7) / 2 -> `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
- DIVU 7 / 0 -> cycle 33 `lo` = 0xFFFFFFFF, `hi` = 0x00000007. DIV 0x80000000 / 0xFFFFFFFF -> `lo` = 0x80000000, `hi` = 0.
- Start MULTU 3 × 4 with prior `hi`/`lo` = 0x11/0x22, assert `flushE` in cycle 10 -> IDLE in cycle 11, `stallE` = 0, `hi`/`lo` stay 0x11/0x22, `done` never asserted.
- Hold `startE` high continuously through cycle 33 -> no restart in DONE; dropping `startE` in cycle 34 leaves the unit in IDLE. A second op started in cycle 34 completes in cycle 67.
- Assert `rst` in cycle 5 of a DIV -> the next cycle is IDLE, `hi` = `lo` = 0, `stallE` = 0, `done` = 0.

Source files
------------

// File: rtl/muldiv_controller.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer for EX: 32 one-bit iterations on operand
// magnitudes, sign fix-up and HI/LO write-back on the last iteration edge.
//
// state  | meaning
// IDLE   | waiting for a mul/div in EX; a start (not flushed) stalls this cycle
// RUN    | one shift-add / restoring-divide iteration per cycle, pipeline stalled
// DONE   | HI/LO just written, done pulsed, instruction still in EX
module muldiv_controller #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcAE,
  input  logic [WIDTH-1:0] srcBE,
  input  logic             flushE,
  output logic             stallE,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;

  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;

  logic               start_ok;
  logic               last_iter;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign start_ok  = (state == S_IDLE) && startE && !flushE;
  assign last_iter = (state == S_RUN) && (cnt == CW'(WIDTH - 1));

  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  assign stallE = !rst && (start_ok || (state == S_RUN));

  // Unsigned ops (opE[0] = 1) keep the raw operand bits.
  assign sign_a = srcAE[WIDTH-1] & ~opE[0];
  assign sign_b = srcBE[WIDTH-1] & ~opE[0];
  assign mag_a  = sign_a ? -srcAE : srcAE;
  assign mag_b  = sign_b ? -srcBE : srcBE;

  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, op_a} : '0);
    prod_nxt = {mul_sum, prod[WIDTH-1:1]};

    // A failed trial subtract implies rem_sh < divisor, so its top bit is zero.
    rem_sh   = {rem, quo[WIDTH-1]};
    div_diff = rem_sh - {1'b0, op_b};
    div_ok   = !div_diff[WIDTH];
    rem_nxt  = div_ok ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nxt  = {quo[WIDTH-2:0], div_ok};

    prod_fix = neg_res ? -prod_nxt : prod_nxt;
    quo_fix  = neg_res ? -quo_nxt  : quo_nxt;
    rem_fix  = neg_rem ? -rem_nxt  : rem_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state <= S_RUN;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          if (flushE) begin
            state <= S_IDLE;
          end else if (last_iter) begin
            state <= S_DONE;
            if (is_div) begin
              if (div_zero) begin
                hi <= a_raw;
                lo <= '1;
              end else begin
                hi <= rem_fix;
                lo <= quo_fix;
              end
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers need no reset: they are always loaded before RUN.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      is_div   <= opE[1];
      neg_res  <= sign_a ^ sign_b;
      neg_rem  <= sign_a;
      div_zero <= (srcBE == '0);
      a_raw    <= srcAE;
      op_a     <= mag_a;
      op_b     <= mag_b;
      prod     <= {{WIDTH{1'b0}}, mag_b};
      rem      <= '0;
      quo      <= mag_a;
    end else if (state == S_RUN) begin
      if (is_div) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
      end else begin
        prod <= prod_nxt;
      end
    end
  end

endmodule
